// File: rtl/core_trap_if.sv
// core_trap_if: groups the commit-stage, interrupt, CSR and flush signals of
// the trap controller into one bundle.
//   master : commit stage / CSR file side (drives commit info and CSR read values)
//   slave  : core_trap_ctrl (drives CSR write port, stall and flush)
// Signals:
//   cmt_valid/cmt_pc/cmt_ecall/cmt_ebreak/cmt_mret : committing instruction
//   irq_ext/irq_tmr                                : level interrupt requests
//   csr_mstatus_r/csr_mtvec_r/csr_mepc_r           : current CSR values
//   csr_we/csr_waddr/csr_wdata                     : single CSR write port
//   cmt_stall/flush_req/flush_pc/busy              : pipeline control
interface core_trap_if #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
);
  logic                cmt_valid;
  logic [PC_WIDTH-1:0] cmt_pc;
  logic                cmt_ecall;
  logic                cmt_ebreak;
  logic                cmt_mret;
  logic                irq_ext;
  logic                irq_tmr;
  logic [XLEN-1:0]     csr_mstatus_r;
  logic [XLEN-1:0]     csr_mtvec_r;
  logic [XLEN-1:0]     csr_mepc_r;
  logic                csr_we;
  logic [11:0]         csr_waddr;
  logic [XLEN-1:0]     csr_wdata;
  logic                cmt_stall;
  logic                flush_req;
  logic [PC_WIDTH-1:0] flush_pc;
  logic                busy;

  modport master (
    output cmt_valid, cmt_pc, cmt_ecall, cmt_ebreak, cmt_mret,
    output irq_ext, irq_tmr, csr_mstatus_r, csr_mtvec_r, csr_mepc_r,
    input  csr_we, csr_waddr, csr_wdata, cmt_stall, flush_req, flush_pc, busy
  );

  modport slave (
    input  cmt_valid, cmt_pc, cmt_ecall, cmt_ebreak, cmt_mret,
    input  irq_ext, irq_tmr, csr_mstatus_r, csr_mtvec_r, csr_mepc_r,
    output csr_we, csr_waddr, csr_wdata, cmt_stall, flush_req, flush_pc, busy
  );
endinterface

// File: rtl/core_trap_ctrl.sv
// core_trap_ctrl: sequences trap entry (ecall, ebreak, external/timer
// interrupt) and mret at the commit boundary. Trap entry writes mepc, mcause
// and mstatus one per cycle through the single CSR write port, then issues a
// one-cycle flush to the handler; mret writes mstatus and flushes to mepc.
// Commit is stalled from the detect cycle until the flush cycle inclusive.
// Ports:
//   clk  : core clock
//   rst  : asynchronous reset, active-high
//   bus  : core_trap_if.slave (commit info, interrupts, CSR read/write, flush)
module core_trap_ctrl #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  core_trap_if.slave  bus
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // Interrupt causes carry the MSB set; synchronous exceptions do not.
  localparam logic [XLEN-1:0] CAUSE_EXT    = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [XLEN-1:0] CAUSE_TMR    = {1'b1, {(XLEN-5){1'b0}}, 4'h7};
  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_MEPC,
    S_WR_MCAUSE,
    S_WR_MSTATUS,
    S_MRET_MSTATUS,
    S_FLUSH
  } state_t;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // mret: MIE <= MPIE, MPIE <= 1, MPP stays M-mode (only M-mode exists).
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     r_cause;
  logic [XLEN-1:0]     r_mstatus;
  logic [PC_WIDTH-1:0] r_tvec;
  logic [PC_WIDTH-1:0] r_mepc;
  logic                r_is_mret;

  logic                w_mie;
  logic                w_irq_ext;
  logic                w_irq_tmr;
  logic                w_exc;
  logic                w_detect;
  logic                w_take_mret;
  logic                w_busy;
  logic [XLEN-1:0]     w_cause;
  logic                w_unused_bits;

  // Direct-mode vectoring only, so the mode bits of mtvec are don't-care.
  assign w_unused_bits = ^bus.csr_mtvec_r[1:0];

  // Interrupts are gated by MIE and only taken alongside a committing
  // instruction; they are never latched, so a dropped one is simply re-seen.
  assign w_mie       = bus.csr_mstatus_r[3];
  assign w_irq_ext   = bus.irq_ext & w_mie;
  assign w_irq_tmr   = bus.irq_tmr & w_mie;
  assign w_exc       = w_irq_ext | w_irq_tmr | bus.cmt_ecall | bus.cmt_ebreak;
  assign w_busy      = (r_state != S_IDLE);
  // rst gates detect so that stall stays low while reset is held.
  assign w_detect    = !w_busy && bus.cmt_valid && (w_exc || bus.cmt_mret) && !rst;
  assign w_take_mret = !w_exc;

  always_comb begin
    w_cause = CAUSE_EBREAK;
    if (w_irq_ext)          w_cause = CAUSE_EXT;
    else if (w_irq_tmr)     w_cause = CAUSE_TMR;
    else if (bus.cmt_ecall) w_cause = CAUSE_ECALL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_cause   <= '0;
      r_mstatus <= '0;
      r_tvec    <= '0;
      r_mepc    <= '0;
      r_is_mret <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_detect) begin
        r_pc      <= XLEN'(bus.cmt_pc);
        r_cause   <= w_cause;
        r_mstatus <= bus.csr_mstatus_r;
        r_tvec    <= {bus.csr_mtvec_r[PC_WIDTH-1:2], 2'b00};
        r_mepc    <= bus.csr_mepc_r[PC_WIDTH-1:0];
        r_is_mret <= w_take_mret;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.csr_we    = 1'b0;
    bus.csr_waddr = '0;
    bus.csr_wdata = '0;
    bus.flush_req = 1'b0;
    bus.flush_pc  = '0;
    bus.busy      = w_busy;
    bus.cmt_stall = w_busy | w_detect;
    case (r_state)
      S_IDLE: begin
        if (w_detect) w_state_nxt = w_take_mret ? S_MRET_MSTATUS : S_WR_MEPC;
      end
      S_WR_MEPC: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MEPC;
        bus.csr_wdata = {r_pc[XLEN-1:2], 2'b00};
        w_state_nxt   = S_WR_MCAUSE;
      end
      S_WR_MCAUSE: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MCAUSE;
        bus.csr_wdata = r_cause;
        w_state_nxt   = S_WR_MSTATUS;
      end
      S_WR_MSTATUS: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MSTATUS;
        bus.csr_wdata = trap_mstatus(r_mstatus);
        w_state_nxt   = S_FLUSH;
      end
      S_MRET_MSTATUS: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MSTATUS;
        bus.csr_wdata = mret_mstatus(r_mstatus);
        w_state_nxt   = S_FLUSH;
      end
      S_FLUSH: begin
        // No detect here: the controller is still busy this cycle.
        bus.flush_req = 1'b1;
        bus.flush_pc  = r_is_mret ? r_mepc : r_tvec;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_trap_ctrl.sv
module tb_core_trap_ctrl;

  logic clk = 1'b0;
  logic rst;

  core_trap_if #(.XLEN(32), .PC_WIDTH(32)) u_if ();

  core_trap_ctrl #(.XLEN(32), .PC_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected observable behaviour for one clock cycle.
  typedef struct {
    logic        we;
    logic [11:0] a;
    logic [31:0] d;
    logic        fl;
    logic [31:0] fp;
    logic        st;
    logic        bz;
  } cyc_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic cyc_t mk(input logic we, input logic [11:0] a, input logic [31:0] d,
                              input logic fl, input logic [31:0] fp, input logic st,
                              input logic bz);
    cyc_t c;
    c.we = we; c.a = a; c.d = d; c.fl = fl; c.fp = fp; c.st = st; c.bz = bz;
    return c;
  endfunction

  task automatic check_cycle(input string tag, input cyc_t c);
    chk({tag, ".csr_we"},    32'(u_if.csr_we),    32'(c.we));
    chk({tag, ".csr_waddr"}, 32'(u_if.csr_waddr), 32'(c.a));
    chk({tag, ".csr_wdata"}, u_if.csr_wdata,      c.d);
    chk({tag, ".flush_req"}, 32'(u_if.flush_req), 32'(c.fl));
    chk({tag, ".flush_pc"},  u_if.flush_pc,       c.fp);
    chk({tag, ".cmt_stall"}, 32'(u_if.cmt_stall), 32'(c.st));
    chk({tag, ".busy"},      32'(u_if.busy),      32'(c.bz));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic e, input logic b,
                       input logic m, input logic ext, input logic tmr,
                       input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
    u_if.cmt_valid     = v;
    u_if.cmt_pc        = pc;
    u_if.cmt_ecall     = e;
    u_if.cmt_ebreak    = b;
    u_if.cmt_mret      = m;
    u_if.irq_ext       = ext;
    u_if.irq_tmr       = tmr;
    u_if.csr_mstatus_r = ms;
    u_if.csr_mtvec_r   = tv;
    u_if.csr_mepc_r    = ep;
  endtask

  // Inputs while the controller is busy; hot forces new events to appear.
  task automatic drive_junk(input bit hot);
    if (hot)
      drive(1'b1, $urandom, 1'b0, 1'b1, 1'($urandom), 1'b1, 1'b1, $urandom | 32'h8, $urandom, $urandom);
    else
      drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom, $urandom, $urandom);
  endtask

  // Reference model: decide what the committing cycle takes from the
  // architectural rules, then expand it into the visible cycle sequence.
  task automatic run_case(input string tag, input logic v, input logic [31:0] pc,
                          input logic e, input logic b, input logic m, input logic ext,
                          input logic tmr, input logic [31:0] ms, input logic [31:0] tv,
                          input logic [31:0] ep, input bit hot);
    cyc_t        q[$];
    int          kind;
    logic [31:0] cause;
    logic        mie;
    logic        mpie;
    mie   = ms[3];
    mpie  = ms[7];
    kind  = 0;
    cause = 32'h0;
    if (v) begin
      if (ext && mie)      begin kind = 1; cause = 32'h8000000B; end
      else if (tmr && mie) begin kind = 1; cause = 32'h80000007; end
      else if (e)          begin kind = 1; cause = 32'd11; end
      else if (b)          begin kind = 1; cause = 32'd3; end
      else if (m)          begin kind = 2; end
    end
    if (kind == 0) begin
      q.push_back(mk(0, 12'h0, 32'h0, 0, 32'h0, 0, 0));
    end else if (kind == 1) begin
      q.push_back(mk(0, 12'h0, 32'h0, 0, 32'h0, 1, 0));
      q.push_back(mk(1, 12'h341, pc & ~32'h3, 0, 32'h0, 1, 1));
      q.push_back(mk(1, 12'h342, cause, 0, 32'h0, 1, 1));
      q.push_back(mk(1, 12'h300, (ms & ~32'h1888) | 32'h1800 | (mie ? 32'h80 : 32'h0),
                     0, 32'h0, 1, 1));
      q.push_back(mk(0, 12'h0, 32'h0, 1, tv & ~32'h3, 1, 1));
    end else begin
      q.push_back(mk(0, 12'h0, 32'h0, 0, 32'h0, 1, 0));
      q.push_back(mk(1, 12'h300, (ms & ~32'h1888) | 32'h1880 | (mpie ? 32'h8 : 32'h0),
                     0, 32'h0, 1, 1));
      q.push_back(mk(0, 12'h0, 32'h0, 1, ep, 1, 1));
    end
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i == 0) drive(v, pc, e, b, m, ext, tmr, ms, tv, ep);
      else        drive_junk(hot);
      #1;
      check_cycle($sformatf("%s.c%0d", tag, i), q[i]);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    drive(1'b1, 32'h80000040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0);
    #1;
    check_cycle("reset", mk(0, 12'h0, 32'h0, 0, 32'h0, 0, 0));
    repeat (2) @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;

    // ecall trap with test-plan values
    run_case("ecall", 1, 32'h80000040, 1, 0, 0, 0, 0, 32'h00000008, 32'h80000101, 32'h0, 0);
    run_case("idle_after", 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    // mret
    run_case("mret", 1, 32'h80000050, 0, 0, 1, 0, 0, 32'h00000080, 32'h0, 32'h80000044, 0);
    // Interrupt priority
    run_case("prio_ext", 1, 32'h00001000, 0, 1, 0, 1, 1, 32'h00000008, 32'h00002000, 32'h0, 0);
    run_case("prio_tmr", 1, 32'h00001004, 0, 1, 0, 0, 1, 32'h00000008, 32'h00002000, 32'h0, 0);
    run_case("prio_mie0", 1, 32'h00001008, 0, 1, 0, 1, 1, 32'h00000000, 32'h00002000, 32'h0, 0);
    // Interrupt beats mret; mepc is the mret's pc
    run_case("irq_mret", 1, 32'h0000300C, 0, 0, 1, 0, 1, 32'h00000088, 32'h00004000, 32'h5, 0);
    // Interrupt gating by cmt_valid, then taken
    for (int i = 0; i < 3; i++)
      run_case("gate_idle", 0, 32'h00005000, 0, 0, 0, 0, 1, 32'h00000008, 32'h00006000, 32'h0, 0);
    run_case("gate_take", 1, 32'h00005000, 0, 0, 0, 0, 1, 32'h00000008, 32'h00006000, 32'h0, 0);
    // Busy ignore: events hammered during the sequence
    run_case("busy_ign", 1, 32'h80000040, 1, 0, 0, 0, 0, 32'h00000008, 32'h80000101, 32'h0, 1);
    // Back-to-back: new detect right after flush
    run_case("b2b", 1, 32'h00007000, 0, 1, 0, 0, 0, 32'h00000000, 32'h00008000, 32'h0, 0);

    // Reset in the middle of the mcause write
    @(negedge clk);
    drive(1'b1, 32'h80000040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h80000101, 32'h0);
    @(negedge clk);
    drive_junk(0);
    @(negedge clk);
    drive_junk(1);
    #1;
    chk("rst_mid.pre_we",   32'(u_if.csr_we),    32'h1);
    chk("rst_mid.pre_addr", 32'(u_if.csr_waddr), 32'h342);
    #2;
    rst = 1'b1;
    #1;
    check_cycle("rst_mid.async", mk(0, 12'h0, 32'h0, 0, 32'h0, 0, 0));
    @(negedge clk);
    check_cycle("rst_mid.held", mk(0, 12'h0, 32'h0, 0, 32'h0, 0, 0));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    run_case("post_rst", 1, 32'h80000040, 1, 0, 0, 0, 0, 32'h00000008, 32'h80000101, 32'h0, 0);

    // Randomized events against the model
    for (int n = 0; n < 60; n++) begin
      logic v, e, b, m, ext, tmr;
      v   = ($urandom_range(0, 3) != 0);
      e   = ($urandom_range(0, 3) == 0);
      b   = ($urandom_range(0, 3) == 0);
      m   = ($urandom_range(0, 3) == 0);
      ext = ($urandom_range(0, 3) == 0);
      tmr = ($urandom_range(0, 3) == 0);
      run_case($sformatf("rnd%0d", n), v, $urandom, e, b, m, ext, tmr,
               $urandom, $urandom, $urandom, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
